par2ser_stream: RTL

Parametrised parallel-to-serial converter with a valid/ready input handshake, a selectable bit order, and frame markers on the serial side. It accepts WIDTH-bit words from an upstream producer and emits them one bit per enabled clock. A one-word holding buffer lets consecutive words stream with no idle bit between frames. It replaces the fixed 4-bit, free-running serialiser as the general bit-serialisation stage of the design.

---
 rtl/par2ser_pkg.sv | 11 +
 rtl/par2ser_shift.sv | 45 ++++
 rtl/par2ser_stream.sv | 85 ++++++++
 3 files changed

// File: rtl/par2ser_pkg.sv
// Shared constants and helpers for the par2ser stream serialiser.
package par2ser_pkg;

  localparam bit ORDER_LSB = 1'b0;
  localparam bit ORDER_MSB = 1'b1;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/par2ser_shift.sv
// Shift register and bit counter for one serial frame.
module par2ser_shift
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = ORDER_LSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] data,
  output logic             cur_bit,
  output logic             first,
  output logic             last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= data;
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + CW'(1);
      if (MSB_FIRST == ORDER_MSB)
        sh <= {sh[WIDTH-2:0], 1'b0};
      else
        sh <= {1'b0, sh[WIDTH-1:1]};
    end
  end

  assign cur_bit = (MSB_FIRST == ORDER_MSB) ? sh[WIDTH-1] : sh[0];
  assign first   = (cnt == '0);
  assign last    = (cnt == CNT_MAX);

endmodule

// File: rtl/par2ser_stream.sv
// Parallel-to-serial stream converter with one-word holding buffer.
module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = ORDER_LSB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sout_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_first,
  output logic             dout_last
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;
  logic             load;
  logic             advance;
  logic             finish;
  logic             in_shift;
  logic             cur_bit;
  logic             sh_first;
  logic             sh_last;

  assign in_shift  = (state == S_SHIFT);
  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;

  // Gapless reload when the last bit is consumed and a word waits.
  assign load    = hold_full &&
                   (!in_shift || (sout_en && sh_last));
  assign advance = in_shift && sout_en && !load;
  assign finish  = in_shift && sout_en && sh_last &&
                   !hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load)
        state <= S_SHIFT;
      else if (finish)
        state <= S_IDLE;
    end
  end

  par2ser_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clear   (finish),
    .load    (load),
    .advance (advance),
    .data    (hold),
    .cur_bit (cur_bit),
    .first   (sh_first),
    .last    (sh_last)
  );

  assign dout_valid = in_shift && !rst;
  assign dout       = dout_valid && cur_bit;
  assign dout_first = dout_valid && sh_first;
  assign dout_last  = dout_valid && sh_last;

endmodule
